// File: rtl/div_pkg.sv
// Shared types and sizing for the RV32M divide/remainder unit.
package div_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;
  localparam int unsigned DIV_ADDR_WIDTH = 5;

  // Width of an iteration counter that must reach w-1.
  function automatic int unsigned div_cnt_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DIV_CNT_WIDTH = div_cnt_width(DIV_DATA_WIDTH);

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU, driving the
// register file write port with a one-cycle strobe.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DIV_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DIV_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [1:0]               op_i,
  input  logic [DATA_WIDTH-1:0]    dividend_i,
  input  logic [DATA_WIDTH-1:0]    divisor_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     we_o,
  output logic [ADDRESS_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0]    wd_o
);

  localparam int unsigned CNT_W = div_cnt_width(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  div_state_t state_q, state_d;
  div_op_t    op_q, op_d, op_in;

  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d, rd_addr_d;
  logic [DATA_WIDTH-1:0]    div_q, div_d, quo_q, quo_d, wd_d;
  logic [DATA_WIDTH:0]      rem_q, rem_d, shifted, trial;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     negq_q, negq_d, negr_q, negr_d;
  logic                     busy_d, done_d, we_d;

  logic                  signed_in, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

  assign op_in     = div_op_t'(op_i);
  assign signed_in = (op_in == DIV) || (op_in == REM);
  assign a_neg     = signed_in && dividend_i[DATA_WIDTH-1];
  assign b_neg     = signed_in && divisor_i[DATA_WIDTH-1];
  assign a_abs     = a_neg ? -dividend_i : dividend_i;
  assign b_abs     = b_neg ? -divisor_i : divisor_i;

  // One restoring step: bring in the next dividend bit, then trial-subtract.
  assign shifted = (rem_q << 1) | (DATA_WIDTH + 1)'(quo_q[DATA_WIDTH-1]);
  assign trial   = shifted - {1'b0, div_q};

  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    div_d     = div_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    rd_addr_d = rd_addr_o;
    wd_d      = wd_o;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d   = op_in;
          rd_d   = rd_addr_i;
          cnt_d  = '0;
          negq_d = 1'b0;
          negr_d = 1'b0;
          // Special cases park their final answers in quo/rem and skip CALC.
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend_i};
            state_d = FIN;
          end else if (signed_in && dividend_i == MIN_NEG && divisor_i == '1) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            state_d = FIN;
          end else begin
            div_d   = b_abs;
            quo_d   = a_abs;
            rem_d   = '0;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = trial[DATA_WIDTH] ? shifted : trial;
        quo_d = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIN;
      end
      FIN: begin
        done_d    = 1'b1;
        we_d      = (rd_q != '0);
        rd_addr_d = rd_q;
        wd_d      = (op_q == REM || op_q == REMU) ? r_fix : q_fix;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= DIV;
      rd_q      <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      we_o      <= 1'b0;
      rd_addr_o <= '0;
      wd_o      <= '0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      we_o      <= we_d;
      rd_addr_o <= rd_addr_d;
      wd_o      <= wd_d;
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) feeding the register file write port. It accepts one operation per start pulse, computes it by radix-2 restoring division on operand magnitudes, and presents a one-cycle write strobe with destination address and result. It sits between execute and the register file, so its `we_o`/`rd_addr_o`/`wd_o` drive the register file's write-enable, write-address and write-data inputs.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `ADDRESS_WIDTH`, 5, register address width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start_i`  in  1  request; sampled on rising edge while idle
- `op_i`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `dividend_i`  in  DATA_WIDTH  rs1 value
- `divisor_i`  in  DATA_WIDTH  rs2 value
- `rd_addr_i`  in  ADDRESS_WIDTH  destination register
- `busy_o`  out  1  operation in flight; high when state ≠ IDLE
- `done_o`  out  1  one-cycle completion pulse
- `we_o`  out  1  register-file write enable; equals `done_o` && `rd_addr_o` ≠ 0
- `rd_addr_o`  out  ADDRESS_WIDTH  latched destination
- `wd_o`  out  DATA_WIDTH  result; held until next completion

## Operation
- States: IDLE, CALC, FIN.
- IDLE → CALC on `start_i`. Latch op, rd_addr, |dividend|, |divisor| and the result sign.
  - Signed ops only: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear remainder accumulator; iteration counter = 0.
- IDLE → FIN directly on `start_i` for special cases. The result is latched at start:
  - Divisor = 0: DIV/DIVU → all ones. REM/REMU → dividend.
  - DIV with dividend = 0x80000000 and divisor = 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- CALC: one restoring step per cycle. Shift {rem, quo} left 1, trial-subtract the divisor, set the quotient bit if the result is non-negative. Remainder accumulator is DATA_WIDTH+1 bits. After iteration DATA_WIDTH−1, go to FIN.
- FIN: apply two's-complement sign fix-up. Select quotient or remainder. Register into `wd_o`. Pulse `done_o`. Return to IDLE.
- `start_i` while busy is ignored. Operands are not re-sampled.
- `start_i` in the cycle `done_o` is high is accepted, because the state is already IDLE.
- DIVU/REMU treat operands as unsigned. No sign fix-up.

## Timing
- Reset (async assert, any state): state IDLE, counter 0.
  - `busy_o`, `done_o`, `we_o` = 0.
  - `rd_addr_o` = 0, `wd_o` = 0.
  - An in-flight operation is discarded; no write occurs.
- Edge E0 samples `start_i`. Normal ops: `busy_o` is high E0..E(DATA_WIDTH+1). `done_o`/`we_o` are high for one cycle after edge E(DATA_WIDTH+1), i.e. latency 33 for width 32.
- Special cases: `done_o` is high after E1 (latency 1).
- `busy_o` falls at the same edge `done_o` rises.
- All outputs are registered on the rising edge. The register file samples on the falling edge, so `wd_o`/`rd_addr_o`/`we_o` are stable half a cycle before capture.
- `rd_addr_o` = 0 still pulses `done_o`, but `we_o` stays 0.

## Structure
- `div_pkg`: `div_op_t` enum (DIV, DIVU, REM, REMU), `div_state_t` enum (IDLE, CALC, FIN), iteration-count width constant `$clog2(DATA_WIDTH)`.
- Single module, no sub-module. The datapath (shift/subtract, sign fix-up) is small enough to stay inline.

## Test plan
- DIVU 100 / 7, rd = 5, start at E0 → `done_o` = `we_o` = 1 after E33, `wd_o` = 14, `rd_addr_o` = 5; `busy_o` high for 33 cycles.
- REM −7 / 2 (0xFFFFFFF9, 2) → `wd_o` = 0xFFFFFFFF (−1). DIV with the same operands → 0xFFFFFFFD (−3).
- DIV 42 / 0 → `done_o` after E1, `wd_o` = 0xFFFFFFFF. REMU 42 / 0 → `wd_o` = 42.
- DIV 0x80000000 / 0xFFFFFFFF → `wd_o` = 0x80000000 at E1. REM with the same operands → 0.
- DIVU 10 / 3 started, then second `start_i` (20 / 4) at cycle 5 → only one completion, `wd_o` = 3. A start in the `done_o` cycle is accepted and yields a second result 33 cycles later.
- Assert `rst_n` low at cycle 10 of an operation → all outputs 0 immediately, no `we_o` pulse. DIVU 9 / 3 with rd = 0 → `done_o` pulses, `we_o` stays 0, `wd_o` = 3.
